// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

  localparam int DMEM_DATA_W = 32;
  localparam int DMEM_CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  // True when the byte address has any bit set above the RAM's word range.
  function automatic logic addr_oob(input logic [31:0] addr, input int addr_w);
    return (addr >> (addr_w + 2)) != 32'd0;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word RAM: synchronous write, combinational read.
// Contents are never reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [ADDR_W-1:0]      addr,
  input  logic [DMEM_DATA_W-1:0] wdata,
  output logic [DMEM_DATA_W-1:0] rdata
);

  logic [DMEM_DATA_W-1:0] mem [2**ADDR_W];

  // Write port; the caller gates we so nothing lands during reset.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/data_mem_responder.sv
// Wait-stated data-port memory slave: IDLE -> WAIT (WAIT_CYCLES edges) -> RESP.
// Optional feature macro: DMEM_ALIGN_CHECK_EN flags byte-misaligned accesses.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset_s,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_out,
  input  logic        data_read,
  input  logic        data_write,
  output logic [31:0] data_in,
  output logic        data_ready,
  output logic        data_err
);

  localparam logic [DMEM_CNT_W-1:0] WAIT_LD = DMEM_CNT_W'(WAIT_CYCLES);

  dmem_state_t            state_q, state_d;
  logic [DMEM_CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [DMEM_DATA_W-1:0] wdata_q, wdata_d;
  logic                   rd_q, rd_d;
  logic                   wr_q, wr_d;
  logic                   flag_q, flag_d;
  logic [DMEM_DATA_W-1:0] data_in_q, data_in_d;
  logic                   ready_q, ready_d;
  logic                   err_q, err_d;

  // Access seen by the RAM on a commit edge (live inputs when WAIT_CYCLES = 0).
  logic                   commit;
  logic [ADDR_W-1:0]      cur_addr;
  logic [DMEM_DATA_W-1:0] cur_wdata;
  logic                   cur_rd, cur_wr, cur_flag;

  logic                   req_flag;
  logic                   mem_we;
  logic [DMEM_DATA_W-1:0] mem_rdata;

`ifdef DMEM_ALIGN_CHECK_EN
  logic align_err;
  assign align_err = data_addr[1:0] != 2'b00;
`else
  // Byte offset is ignored: the access targets the word holding the byte.
  logic align_err;
  logic unused_lsb;
  assign align_err  = 1'b0;
  assign unused_lsb = ^data_addr[1:0];
`endif

  // Error classification of the request currently on the inputs.
  always_comb begin
    req_flag = (data_read & data_write) | addr_oob(data_addr, ADDR_W) | align_err;
  end

  // Next-state, capture and commit decode.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    flag_d    = flag_q;
    commit    = 1'b0;
    cur_addr  = addr_q;
    cur_wdata = wdata_q;
    cur_rd    = rd_q;
    cur_wr    = wr_q;
    cur_flag  = flag_q;
    unique case (state_q)
      IDLE: begin
        if (data_read | data_write) begin
          addr_d  = data_addr[ADDR_W+1:2];
          wdata_d = data_out;
          rd_d    = data_read;
          wr_d    = data_write;
          flag_d  = req_flag;
          if (WAIT_CYCLES == 0) begin
            // No wait states: commit straight from the inputs on this edge.
            state_d   = RESP;
            commit    = 1'b1;
            cur_addr  = data_addr[ADDR_W+1:2];
            cur_wdata = data_out;
            cur_rd    = data_read;
            cur_wr    = data_write;
            cur_flag  = req_flag;
          end else begin
            cnt_d   = WAIT_LD;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - DMEM_CNT_W'(1);
        if (cnt_d == '0) begin
          commit  = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Commit effects: RAM write, read-data load and the completion strobes.
  always_comb begin
    mem_we    = commit & cur_wr & ~cur_flag & reset_s;
    data_in_d = data_in_q;
    if (commit && cur_rd) data_in_d = cur_flag ? '0 : mem_rdata;
    ready_d   = commit;
    err_d     = commit & cur_flag;
  end

  // State, counter and output registers; reset abandons any access in flight.
  always_ff @(posedge clk) begin
    if (!reset_s) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      data_in_q <= '0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      data_in_q <= data_in_d;
      ready_q   <= ready_d;
      err_q     <= err_d;
    end
  end

  // Captured request; needs no reset since it is only used after a capture.
  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    rd_q    <= rd_d;
    wr_q    <= wr_d;
    flag_q  <= flag_d;
  end

  dmem_array #(.ADDR_W(ADDR_W)) u_array (
    .clk   (clk),
    .we    (mem_we),
    .addr  (cur_addr),
    .wdata (cur_wdata),
    .rdata (mem_rdata)
  );

  assign data_in    = data_in_q;
  assign data_ready = ready_q;
  assign data_err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench: two responders (WAIT_CYCLES = 1 and 0) checked against a word-array model.
module tb_data_mem_responder;

`ifdef DMEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic [1:0]  rst_n, rd, wr, rdy, er;
  logic [31:0] addr [2];
  logic [31:0] wd   [2];
  logic [31:0] din  [2];

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] mdl  [2][1024];
  logic [31:0] dexp [2];

  always #5 clk = ~clk;

  data_mem_responder #(.ADDR_W(10), .WAIT_CYCLES(1)) u_dut_w1 (
    .clk(clk), .reset_s(rst_n[0]), .data_addr(addr[0]), .data_out(wd[0]),
    .data_read(rd[0]), .data_write(wr[0]), .data_in(din[0]),
    .data_ready(rdy[0]), .data_err(er[0])
  );

  data_mem_responder #(.ADDR_W(10), .WAIT_CYCLES(0)) u_dut_w0 (
    .clk(clk), .reset_s(rst_n[1]), .data_addr(addr[1]), .data_out(wd[1]),
    .data_read(rd[1]), .data_write(wr[1]), .data_in(din[1]),
    .data_ready(rdy[1]), .data_err(er[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One access on instance i: model update, drive, bounded wait for ready, check.
  task automatic access(input int i, input bit r, input bit w,
                        input logic [31:0] a, input logic [31:0] d);
    int wc;
    bit e, got;
    int lat;
    wc = (i == 0) ? 1 : 0;
    e  = (r && w) || (a[31:12] != 0) || (ALIGN && a[1:0] != 2'b00);
    if (r) dexp[i] = e ? 32'h0 : mdl[i][a[11:2]];
    if (w && !e) mdl[i][a[11:2]] = d;
    rd[i] = r; wr[i] = w; addr[i] = a; wd[i] = d;
    got = 1'b0;
    lat = 0;
    for (int n = 1; n <= wc + 4 && !got; n++) begin
      @(posedge clk); #1;
      if (rdy[i]) begin
        got = 1'b1;
        lat = n;
      end else if (n == 1) begin
        // captured already: address/data changes must not matter
        addr[i] = $urandom;
        wd[i]   = $urandom;
      end
    end
    rd[i] = 1'b0; wr[i] = 1'b0; addr[i] = $urandom; wd[i] = $urandom;
    chk($sformatf("latency[%0d] a=%h", i, a), lat, wc + 1);
    chk($sformatf("data_in[%0d] a=%h", i, a), din[i], dexp[i]);
    chk($sformatf("data_err[%0d] a=%h", i, a), {31'b0, er[i]}, {31'b0, e});
    @(posedge clk); #1;
    chk($sformatf("ready_drop[%0d]", i), {31'b0, rdy[i]}, 32'h0);
  endtask

  initial begin
    rst_n = 2'b00; rd = 2'b00; wr = 2'b00;
    for (int i = 0; i < 2; i++) begin
      addr[i] = '0; wd[i] = '0; dexp[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("reset_data_in[%0d]", i), din[i], 32'h0);
      chk($sformatf("reset_ready[%0d]", i), {31'b0, rdy[i]}, 32'h0);
      chk($sformatf("reset_err[%0d]", i), {31'b0, er[i]}, 32'h0);
    end
    rst_n = 2'b11;
    @(posedge clk); #1;

    // basic write/read, one wait state
    access(0, 0, 1, 32'h10, 32'hDEADBEEF);
    access(0, 1, 0, 32'h10, 32'h0);
    // zero wait states, back-to-back reads
    access(1, 0, 1, 32'h0, 32'h1);
    access(1, 0, 1, 32'h4, 32'h2);
    access(1, 1, 0, 32'h0, 32'h0);
    access(1, 1, 0, 32'h4, 32'h0);
    // both directions at once: flagged, memory untouched
    access(0, 0, 1, 32'h8, 32'hA5A5A5A5);
    access(0, 1, 1, 32'h8, 32'hFFFF0000);
    access(0, 1, 0, 32'h8, 32'h0);
    // out of range, then misaligned
    access(0, 0, 1, 32'h4, 32'h44444444);
    access(0, 1, 0, 32'h0001_0000, 32'h0);
    access(0, 1, 0, 32'h6, 32'h0);
    access(1, 1, 0, 32'h0001_0004, 32'h0);
    access(1, 1, 0, 32'h6, 32'h0);

    // reset while a write sits in WAIT
    access(0, 0, 1, 32'hC, 32'h12345678);
    wr[0] = 1'b1; addr[0] = 32'hC; wd[0] = 32'h55;
    @(posedge clk); #1;
    rst_n[0] = 1'b0;
    @(posedge clk); #1;
    wr[0] = 1'b0;
    chk("rst_wait_ready", {31'b0, rdy[0]}, 32'h0);
    chk("rst_wait_err", {31'b0, er[0]}, 32'h0);
    chk("rst_wait_data_in", din[0], 32'h0);
    dexp[0] = 32'h0;
    rst_n[0] = 1'b1;
    @(posedge clk); #1;
    chk("rst_release_ready", {31'b0, rdy[0]}, 32'h0);
    access(0, 1, 0, 32'hC, 32'h0);

    // randomized traffic over a 16-word window
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < 16; k++) access(i, 0, 1, 32'(k * 4), $urandom);
    for (int t = 0; t < 300; t++) begin
      int i, op;
      logic [31:0] a;
      i  = t % 2;
      op = $urandom_range(0, 7);
      a  = {26'b0, 4'($urandom_range(0, 15)), 2'b00};
      if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 7) == 0) a = a | (32'h1 << $urandom_range(12, 31));
      access(i, (op < 4) || (op == 7), op >= 4, a, $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Word-addressed data-memory responder that services the core's data-side load/store requests (`data_read`, `data_write`, `data_addr`, `data_out`) and returns read data on `data_in`. It replaces the zero-latency behavioural memory model on the data port with a registered, wait-stated slave that has an explicit `data_ready` completion strobe and an error flag. It sits between the processor top level and the data RAM. The instruction port is unaffected.

## Interface
- `ADDR_W`, 10: word-address bits; capacity is 2^ADDR_W 32-bit words.
- `WAIT_CYCLES`, 1: extra wait states per access, 0..15.
- `clk` input 1: system clock; all state is updated on its rising edge.
- `reset_s` input 1: synchronous, active-low reset.
- `data_addr` input 32: byte address from the core.
- `data_out` input 32: store data from the core.
- `data_read` input 1: load request level.
- `data_write` input 1: store request level.
- `data_in` output 32: registered load data to the core.
- `data_ready` output 1: one-cycle completion strobe.
- `data_err` output 1: one-cycle error strobe, coincident with `data_ready`.

## Operation
- The FSM has three states:
  - IDLE: when `data_read` or `data_write` is high, capture the address, data and direction, load the counter with WAIT_CYCLES, and go to WAIT. If WAIT_CYCLES = 0, go directly to RESP.
  - WAIT: decrement the counter on each edge. When the counter equals 0, commit the access and go to RESP.
  - RESP: drive `data_ready` = 1, and `data_err` if the access was flagged. Requests are ignored in this state. Next state is always IDLE.
- Commit:
  - A read registers `mem[addr[ADDR_W+1:2]]` into `data_in`.
  - A write stores the captured `data_out`.
  - A flagged access leaves memory unchanged. A flagged read loads `data_in` = 0.
- Error conditions, evaluated at capture:
  - `data_read` and `data_write` both high.
  - `data_addr[31:ADDR_W+2]` is nonzero (out of range).
  - The alignment check under Configuration.
- The core holds the request stable until it sees `data_ready`. Changes to the inputs after capture have no effect.
- `data_in` holds the last read result. Writes do not change it.

## Timing
- Reset values (on a `reset_s` = 0 edge):
  - State = IDLE, counter = 0.
  - `data_in` = 0, `data_ready` = 0, `data_err` = 0.
  - The memory array is NOT cleared.
- Reset during WAIT aborts the access. No write commits and no `data_ready` is issued.
- Latency: a request sampled at edge k produces `data_ready` high during the cycle after edge k+1+WAIT_CYCLES−1, i.e. WAIT_CYCLES+1 cycles after capture.
- Read data is valid in the same cycle as `data_ready`.
- The write lands on the same edge on which `data_ready` rises.
- Throughput is one access per WAIT_CYCLES+2 cycles, because RESP always returns to IDLE.
- A request held high through RESP is re-captured in IDLE as a new access. The core must drop it in the cycle after `data_ready`.
- Write followed by a read of the same word returns the new data, since the write commits before the read is captured.

## Configuration
- `DMEM_ALIGN_CHECK_EN` defined: `data_addr[1:0]` ≠ 0 sets the error flag. The access does not commit, and a read returns 0.
- Not defined: `data_addr[1:0]` is ignored and the access proceeds on the word containing the byte.

## Structure
- Package `dmem_pkg` holds:
  - State enum `dmem_state_t` {IDLE, WAIT, RESP}.
  - `DMEM_DATA_W` = 32.
  - Counter width = 4.
- Sub-module `dmem_array`: a single-port synchronous RAM with write enable, parameterised by ADDR_W.
- The FSM, counter, capture registers and error logic stay in `data_mem_responder`.

## Test plan
- Reset, then a write of 0xDEADBEEF to 0x0000_0010 and a read of 0x10 with WAIT_CYCLES = 1 → `data_ready` 2 cycles after each capture; `data_in` = 0xDEADBEEF, `data_err` = 0.
- WAIT_CYCLES = 0, back-to-back reads of 0x0 and 0x4 preloaded with 0x1 and 0x2 → `data_ready` 1 cycle after capture, one IDLE gap between accesses; `data_in` = 0x1 then 0x2.
- `data_read` and `data_write` both high at 0x8 → `data_ready` and `data_err` = 1; memory at 0x8 unchanged; `data_in` = 0.
- Out-of-range address 0x0001_0000 with ADDR_W = 10 → `data_err` = 1 and `data_in` = 0. Misaligned 0x6 → err with the macro defined; without it, returns the word at 0x4.
- `reset_s` low during WAIT of a write of 0x55 to 0xC → no `data_ready`, 0xC retains its old value, all outputs 0.
- Read after reset of a previously written word → returns the pre-reset value, confirming the array survives reset.
